// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line typedefs plus the pmem responder state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  typedef enum logic [1:0] {
    PM_IDLE,
    PM_BUSY,
    PM_RESP
  } lc3b_pmem_state_t;

  localparam int LC3B_LINE_OFFSET_BITS = 4;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port line store: synchronous write, registered read-before-write, no reset.
module pmem_line_array #(
  parameter int INDEX_BITS = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [127:0]          wdata,
  output logic [127:0]          rdata
);

  logic [127:0] mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
    rdata <= mem[index];
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory line responder: accepts one line read/write at a time and answers
// after a fixed latency with a single-cycle pmem_resp pulse.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 12
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_word pmem_address,
  input  lc3b_data pmem_wdata,
  output logic     pmem_resp,
  output lc3b_data pmem_rdata,
  output logic     proto_err
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("pmem_line_responder: LATENCY must be within 1..15");
  end

  lc3b_pmem_state_t      state;
  logic [CNT_W-1:0]      cnt;
  logic                  op_write;
  logic [INDEX_BITS-1:0] line_index;
  lc3b_data              line_wdata;

  logic [INDEX_BITS-1:0] arr_index;
  logic                  arr_we;
  lc3b_data              arr_rdata;
  logic                  req_held;
  logic                  unused_addr;

  // Offset bits and any bits above the index are deliberately ignored (aliasing).
  assign unused_addr = ^pmem_address;

  // Present the incoming index while idle so read data is ready even when LATENCY=1.
  assign arr_index = (state == PM_IDLE)
                   ? pmem_address[INDEX_BITS+LC3B_LINE_OFFSET_BITS-1:LC3B_LINE_OFFSET_BITS]
                   : line_index;

  assign req_held = op_write ? pmem_write : pmem_read;
  assign arr_we   = (state == PM_BUSY) && op_write && req_held && (cnt == '0);

  pmem_line_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .index(arr_index),
    .wdata(line_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PM_IDLE;
      cnt        <= '0;
      op_write   <= 1'b0;
      line_index <= '0;
      line_wdata <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      case (state)
        PM_IDLE: begin
          if (pmem_read || pmem_write) begin
            // A simultaneous read+write is flagged and served as a write.
            op_write   <= pmem_write;
            line_index <= arr_index;
            line_wdata <= pmem_wdata;
            cnt        <= CNT_W'(LATENCY - 1);
            state      <= PM_BUSY;
            if (pmem_read && pmem_write) proto_err <= 1'b1;
          end
        end
        PM_BUSY: begin
          if (!req_held) begin
            state <= PM_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= PM_RESP;
            pmem_resp <= 1'b1;
            if (!op_write) pmem_rdata <= arr_rdata;
          end
        end
        PM_RESP: state <= PM_IDLE;
        default: state <= PM_IDLE;
      endcase
    end
  end

endmodule
